// File: rtl/mext_pkg.sv
// Shared types for the RV32M multiply sequencer.
//   XLEN        : operand width; the iterative core runs XLEN steps
//   mul_op_e    : funct3[1:0] encoding of the multiply group
//   mul_state_e : sequencer FSM states
package mext_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_e;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Pipeline <-> multiply sequencer bundle.
//   master : E-stage side (drives request, operands, flush; sees stall/result)
//   slave  : sequencer side
//   req_i/mul_op_i/rs1_i/rs2_i/flush_i : request and operands
//   stall_o/result_o/result_valid_o/busy_o : pipeline hold and result return
interface mul_seq_ctrl_if #(
    parameter int unsigned XLEN = mext_pkg::XLEN
);
    logic            req_i;
    logic [1:0]      mul_op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            stall_o;
    logic [XLEN-1:0] result_o;
    logic            result_valid_o;
    logic            busy_o;

    modport master (
        output req_i, mul_op_i, rs1_i, rs2_i, flush_i,
        input  stall_o, result_o, result_valid_o, busy_o
    );

    modport slave (
        input  req_i, mul_op_i, rs1_i, rs2_i, flush_i,
        output stall_o, result_o, result_valid_o, busy_o
    );
endinterface

// File: rtl/mul_iter_core.sv
// Unsigned shift-add multiplier, one multiplier bit per step.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load a/b, clear accumulator
//   a, b     : unsigned multiplicand / multiplier
//   step     : perform one shift-add iteration
//   prod     : accumulator value as it will be after this cycle
//              (includes the step applied this cycle, so the controller can
//              register the final product on the same edge as the last step)
module mul_iter_core #(
    parameter int unsigned XLEN = mext_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              step,
    output logic [2*XLEN-1:0] prod
);
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            mcand_d  = {{XLEN{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    assign prod = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: rtl/mul_seq_ctrl.sv
// E-stage sequencer for MUL/MULH/MULHSU/MULHU.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mul_seq_ctrl_if (request/operands/flush in,
//              stall/result/result_valid/busy out)
// Operands are reduced to magnitudes, multiplied by mul_iter_core over XLEN
// cycles, then sign-corrected and the low or high word is returned with a
// one-cycle valid pulse in DONE. ZERO_FAST lets a zero operand skip the core.
module mul_seq_ctrl
    import mext_pkg::*;
#(
    parameter int unsigned XLEN      = mext_pkg::XLEN,
    parameter bit          ZERO_FAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mul_seq_ctrl_if.slave    bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    mul_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    mul_op_e           op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    mul_op_e           op_in;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              accept, fast;
    logic              core_start, core_step;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   word_sel;
    logic              stall, valid;

    mul_iter_core #(.XLEN(XLEN)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (core_start),
        .a     (mag_a),
        .b     (mag_b),
        .step  (core_step),
        .prod  (prod)
    );

    always_comb begin
        op_in  = mul_op_e'(bus.mul_op_i);
        sign_a = (op_in != MULHU) && bus.rs1_i[XLEN-1];
        sign_b = ((op_in == MUL) || (op_in == MULH)) && bus.rs2_i[XLEN-1];
        // -0x80.. wraps to 0x80.., which read unsigned is the exact magnitude
        mag_a  = sign_a ? -bus.rs1_i : bus.rs1_i;
        mag_b  = sign_b ? -bus.rs2_i : bus.rs2_i;
        accept = bus.req_i && !bus.flush_i;
        fast   = ZERO_FAST && ((bus.rs1_i == '0) || (bus.rs2_i == '0));

        prod_s   = neg_q ? -prod : prod;
        word_sel = (op_q == MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        result_d   = result_q;
        core_start = 1'b0;
        core_step  = 1'b0;
        stall      = 1'b0;
        valid      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    stall = 1'b1;
                    op_d  = op_in;
                    neg_d = sign_a ^ sign_b;
                    cnt_d = '0;
                    if (fast) begin
                        state_d  = DONE;
                        result_d = '0;
                    end else begin
                        state_d    = BUSY;
                        core_start = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    stall     = 1'b1;
                    core_step = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        result_d = word_sel;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                valid   = !bus.flush_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.stall_o        = stall;
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = valid;
    assign bus.busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: a vector table of multiplies with
// hand-computed results and latencies, plus flush, reset and flush-vs-request
// sequences.
module tb_mul_seq_ctrl;
    import mext_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.XLEN(32)) bus ();

    mul_seq_ctrl #(.XLEN(32), .ZERO_FAST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    // Entered just after a posedge while the DUT is idle; that cycle is cycle 0.
    task automatic run_vec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat, input string nm);
        int          got_lat = -1;
        logic [31:0] got_res = '0;
        int          stall_err = 0;
        bus.req_i    = 1'b1;
        bus.mul_op_i = op;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.flush_i  = 1'b0;
        #1;
        if (bus.stall_o !== 1'b1) stall_err++;
        for (int c = 1; c <= lat + 2 && got_lat < 0; c++) begin
            @(posedge clk); #1;
            if (bus.result_valid_o === 1'b1) begin
                got_lat = c;
                got_res = bus.result_o;
                if (bus.stall_o !== 1'b0) stall_err++;
            end else if (bus.stall_o !== 1'b1) begin
                stall_err++;
            end
        end
        bus.req_i = 1'b0;
        chk({nm, "/latency"}, 64'(got_lat), 64'(lat));
        chk({nm, "/result"}, {32'h0, got_res}, {32'h0, exp});
        chk({nm, "/stall_errs"}, 64'(stall_err), 64'd0);
        @(posedge clk); #1;
        chk({nm, "/idle_after"}, {62'h0, bus.result_valid_o, bus.busy_o}, 64'd0);
        chk({nm, "/result_hold"}, {32'h0, bus.result_o}, {32'h0, exp});
    endtask

    initial begin
        int vcount;

        vt[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3"};
        vt[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min_min"};
        vt[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max_max"};
        vt[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1_max"};
        vt[4]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, "mulh_m1_1"};
        vt[5]  = '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1,  "mul_fast_b0"};
        vt[6]  = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1,  "mulh_fast_a0"};
        vt[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_m1_m1"};
        vt[8]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_m1_m1"};
        vt[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33, "mulhu_2p31_2"};
        vt[10] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulhsu_min_2"};
        vt[11] = '{2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 33, "mulhsu_2_2p31"};
        vt[12] = '{2'b01, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 33, "mulh_1_min"};

        rst          = 1'b1;
        bus.req_i    = 1'b0;
        bus.mul_op_i = 2'b00;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        bus.flush_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/outs", {bus.stall_o, bus.result_valid_o, bus.busy_o, bus.result_o}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, vt[i].nm);
        end

        // Flush during MULHU at cycle 10: stall drops combinationally, no pulse.
        vcount = 0;
        bus.req_i    = 1'b1;
        bus.mul_op_i = 2'b11;
        bus.rs1_i    = 32'hFFFF_FFFF;
        bus.rs2_i    = 32'hFFFF_FFFF;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.result_valid_o === 1'b1) vcount++;
        end
        chk("flush/busy_before", {63'h0, bus.busy_o}, 64'd1);
        bus.flush_i = 1'b1;
        bus.req_i   = 1'b0;
        #1;
        chk("flush/stall_comb", {63'h0, bus.stall_o}, 64'd0);
        chk("flush/valid_comb", {63'h0, bus.result_valid_o}, 64'd0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk("flush/busy_after", {63'h0, bus.busy_o}, 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.result_valid_o === 1'b1) vcount++;
        end
        chk("flush/no_pulse", 64'(vcount), 64'd0);
        run_vec(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_after_flush");

        // Asynchronous reset at cycle 20 of a MUL.
        vcount = 0;
        bus.req_i    = 1'b1;
        bus.mul_op_i = 2'b00;
        bus.rs1_i    = 32'h0000_0007;
        bus.rs2_i    = 32'hFFFF_FFFD;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.result_valid_o === 1'b1) vcount++;
        end
        chk("rst/busy_before", {63'h0, bus.busy_o}, 64'd1);
        rst       = 1'b1;
        bus.req_i = 1'b0;
        #1;
        chk("rst/outs", {bus.stall_o, bus.result_valid_o, bus.busy_o, bus.result_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.result_valid_o === 1'b1 || bus.busy_o === 1'b1) vcount++;
        end
        chk("rst/no_pulse", 64'(vcount), 64'd0);

        // Flush and request together in IDLE: must not start.
        bus.req_i    = 1'b1;
        bus.flush_i  = 1'b1;
        bus.mul_op_i = 2'b00;
        bus.rs1_i    = 32'd3;
        bus.rs2_i    = 32'd5;
        #1;
        chk("flushreq/stall", {63'h0, bus.stall_o}, 64'd0);
        @(posedge clk); #1;
        chk("flushreq/busy", {63'h0, bus.busy_o}, 64'd0);
        bus.req_i   = 1'b0;
        bus.flush_i = 1'b0;
        @(posedge clk); #1;
        run_vec(2'b00, 32'd3, 32'd5, 32'd15, 33, "mul_3x5_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
